// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer, polarity normalization and a
// four-state stability FSM that emits a debounced level plus press/release strobes.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic button_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] L_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] L_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] L_CNT_ZERO = {CW{1'b0}};
  localparam logic L_IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  logic          r_s1;
  logic          r_s2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          r_press;
  logic          r_release;

  logic          w_level;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_out_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;

  assign w_level = ACTIVE_LOW ? ~r_s2 : r_s2;

  // Next-state logic: a bounce back to the held level abandons the count silently.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_out_nxt     = r_out;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (w_level) begin
          w_state_nxt = ST_WAIT_PRESS;
          w_cnt_nxt   = L_CNT_ZERO;
        end else begin
          w_state_nxt = ST_RELEASED;
        end
      end
      ST_WAIT_PRESS: begin
        if (w_level == r_out) begin
          w_state_nxt = ST_RELEASED;
          w_cnt_nxt   = L_CNT_ZERO;
        end else if (r_cnt == L_CNT_LAST) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = L_CNT_ZERO;
          w_out_nxt   = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + L_CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!w_level) begin
          w_state_nxt = ST_WAIT_RELEASE;
          w_cnt_nxt   = L_CNT_ZERO;
        end else begin
          w_state_nxt = ST_PRESSED;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_level == r_out) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = L_CNT_ZERO;
        end else if (r_cnt == L_CNT_LAST) begin
          w_state_nxt   = ST_RELEASED;
          w_cnt_nxt     = L_CNT_ZERO;
          w_out_nxt     = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + L_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
        w_cnt_nxt   = L_CNT_ZERO;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  // State, synchronizer and output registers; reset presets the synchronizer to the idle pin level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= L_IDLE_PIN;
      r_s2      <= L_IDLE_PIN;
      r_state   <= ST_RELEASED;
      r_cnt     <= L_CNT_ZERO;
      r_out     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= button_in;
      r_s2      <= r_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_out     <= w_out_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign button_out    = r_out;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
// directed scenarios plus a random glitch soak against a run-length reference model.
module tb_button_debouncer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button_in = 1'b1;
  logic button_out;
  logic press_pulse;
  logic release_pulse;

  button_debouncer #(.DEBOUNCE_CYCLES(N), .ACTIVE_LOW(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .button_in    (button_in),
    .button_out   (button_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_press = 0;
  int n_rel = 0;
  int first_press = -1;
  int first_rel = -1;
  int last_pulse = -1000;

  // reference model: pin seen two edges late, output flips after N+1 disagreeing samples
  logic m_d1 = 1'b1;
  logic m_d2 = 1'b1;
  logic m_out = 1'b0;
  logic m_press = 1'b0;
  logic m_rel = 1'b0;
  int   streak = 0;

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic pin, input logic rst);
    logic pressed_seen;
    button_in = pin;
    reset = rst;
    @(posedge clk);
    cyc++;
    m_press = 1'b0;
    m_rel = 1'b0;
    if (rst) begin
      m_d1 = 1'b1;
      m_d2 = 1'b1;
      m_out = 1'b0;
      streak = 0;
    end else begin
      pressed_seen = ~m_d2;
      m_d2 = m_d1;
      m_d1 = pin;
      if (pressed_seen != m_out) begin
        streak++;
        if (streak == N + 1) begin
          m_out = ~m_out;
          if (m_out) m_press = 1'b1;
          else m_rel = 1'b1;
          streak = 0;
        end
      end else begin
        streak = 0;
      end
    end
    #1;
    chk("button_out", button_out, m_out);
    chk("press_pulse", press_pulse, m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("pulse_exclusive", press_pulse & release_pulse, 1'b0);
    if (press_pulse || release_pulse) begin
      total++;
      assert (cyc - last_pulse >= N + 1) else begin
        bad++;
        $error("FAIL pulse_spacing observed=%0d expected>=%0d", cyc - last_pulse, N + 1);
      end
      last_pulse = cyc;
    end
    if (press_pulse) begin
      n_press++;
      if (first_press < 0) first_press = cyc;
    end
    if (release_pulse) begin
      n_rel++;
      if (first_rel < 0) first_rel = cyc;
    end
  endtask

  initial begin
    int base;
    int np0;
    int nr0;
    int left;
    int run;

    // reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("reset_out", button_out, 1'b0);
    chk("reset_press", press_pulse, 1'b0);
    chk("reset_release", release_pulse, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // clean press: e0 is the first step driving 0
    base = cyc; first_press = -1; np0 = n_press;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    chk_int("clean_press_latency", first_press - base - 1, 6);
    chk_int("clean_press_count", n_press - np0, 1);
    chk("clean_press_level", button_out, 1'b1);

    // clean release
    base = cyc; first_rel = -1; nr0 = n_rel;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    chk_int("clean_release_latency", first_rel - base - 1, 6);
    chk_int("clean_release_count", n_rel - nr0, 1);
    chk("clean_release_level", button_out, 1'b0);

    // bounce rejection from released
    np0 = n_press; nr0 = n_rel;
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    chk_int("bounce_pulses", (n_press - np0) + (n_rel - nr0), 0);
    chk("bounce_level", button_out, 1'b0);

    // press, then bouncy release 1,0,1 then held 1
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    chk("bouncy_pre_level", button_out, 1'b1);
    base = cyc; first_rel = -1; nr0 = n_rel;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    chk_int("bouncy_release_count", n_rel - nr0, 1);
    chk_int("bouncy_release_latency", first_rel - base - 1, 2 + 6);
    chk("bouncy_release_level", button_out, 1'b0);

    // reset mid-count at step 3 of a held press
    base = cyc; first_press = -1; np0 = n_press;
    for (int k = 0; k < 16; k++) step(1'b0, (k == 3) ? 1'b1 : 1'b0);
    chk_int("midreset_press_count", n_press - np0, 1);
    chk_int("midreset_press_at", first_press - base - 1, 3 + 1 + 6);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
    chk("midreset_released", button_out, 1'b0);

    // button held through reset
    step(1'b0, 1'b1); step(1'b0, 1'b1);
    base = cyc; first_press = -1; np0 = n_press; nr0 = n_rel;
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0);
    chk_int("held_press_at", first_press - base - 1, 6);
    chk_int("held_release_count", n_rel - nr0, 0);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);

    // random glitch soak: glitches of 1..3 cycles separated by idle gaps
    np0 = n_press; nr0 = n_rel;
    left = 10000;
    while (left > 0) begin
      run = $urandom_range(8, 1);
      for (int k = 0; k < run && left > 0; k++) begin step(1'b1, 1'b0); left--; end
      run = $urandom_range(3, 1);
      for (int k = 0; k < run && left > 0; k++) begin step(1'b0, 1'b0); left--; end
    end
    step(1'b1, 1'b0);
    chk_int("soak_pulses", (n_press - np0) + (n_rel - nr0), 0);
    chk("soak_level", button_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive stable cycles needed to accept a level change (1 ms at 50 MHz); legal range is 2 to 2^20.
REQ-002 The module SHALL have parameter ACTIVE_LOW, default 1; 1 means the raw pin reads 0 when pressed, 0 means the pin reads 1 when pressed.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port button_in, input, 1 bit: raw, asynchronous, bouncing push-button pin.
REQ-006 The module SHALL have port button_out, output, 1 bit: debounced level, 1 = pressed; it drives in_port of the Botao PIO.
REQ-007 The module SHALL have port press_pulse, output, 1 bit: one-cycle strobe on an accepted press.
REQ-008 The module SHALL have port release_pulse, output, 1 bit: one-cycle strobe on an accepted release.

Function
REQ-009 button_in SHALL pass through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-010 The synchronized value SHALL be normalized to 1 = pressed, inverting when ACTIVE_LOW=1.
REQ-011 The FSM SHALL have four states: RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-012 button_out SHALL be 1 in PRESSED and WAIT_RELEASE, and 0 in RELEASED and WAIT_PRESS.
REQ-013 In RELEASED, a normalized 1 SHALL move the FSM to WAIT_PRESS and clear the counter to 0.
REQ-014 In PRESSED, a normalized 0 SHALL move the FSM to WAIT_RELEASE and clear the counter to 0.
REQ-015 In WAIT_*, while the normalized level still differs from button_out, the counter SHALL increment by 1 per cycle.
REQ-016 In WAIT_*, when the counter equals DEBOUNCE_CYCLES-1 and the level still differs, the FSM SHALL move to the new stable state at that edge.
REQ-017 On that WAIT_* exit edge, button_out SHALL toggle and the matching pulse SHALL be 1 for exactly the following cycle.
REQ-018 In WAIT_*, if the normalized level returns to the button_out value (a bounce), the FSM SHALL return to the prior stable state, clear the counter, and emit no pulse.
REQ-019 Latency for a clean edge SHALL be as follows: if the pin is first sampled at the new level at edge e0, button_out changes at edge e0+DEBOUNCE_CYCLES+2.
REQ-020 The counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide, unsigned, and SHALL never wrap, because it is cleared or exits at DEBOUNCE_CYCLES-1.
REQ-021 press_pulse and release_pulse SHALL never both be 1 in the same cycle.
REQ-022 Two consecutive pulses SHALL be separated by at least DEBOUNCE_CYCLES+1 cycles.
REQ-023 Pin activity shorter than DEBOUNCE_CYCLES consecutive synchronized cycles SHALL produce no output change.

Reset
REQ-024 While reset=1 at a rising edge, the following SHALL be set:
- state = RELEASED
- counter = 0
- button_out = 0, press_pulse = 0, release_pulse = 0
- s1 and s2 = the released pin level (1 if ACTIVE_LOW=1, else 0)
REQ-025 Reset asserted in any state, including mid-count in WAIT_*, SHALL discard the partial count and emit no pulse.
REQ-026 If the button is held through reset deassertion, it SHALL be treated as a new press: press_pulse fires DEBOUNCE_CYCLES+2 edges after the first post-reset edge that samples it.

Verification
All scenarios use DEBOUNCE_CYCLES=4 and ACTIVE_LOW=1.
REQ-027 Clean press: button_in goes 1->0, sampled at edge e0 and held -> button_out=1 and press_pulse=1 at e6; press_pulse=0 at e7.
REQ-028 Bounce rejection: button_in pattern 0,1,0,1 for one cycle each, then held 1 from a released start -> button_out stays 0 and no pulses at any cycle.
REQ-029 Press then bouncy release: from PRESSED, button_in pattern 1,0,1 then held 1 -> exactly one release_pulse, 6 edges after the final 0->1 sampling edge; button_out=0 from then on.
REQ-030 Reset mid-count: button_in=0 held; reset=1 for one cycle at e3 -> no press_pulse before e3+1+6; press_pulse occurs exactly once afterwards.
REQ-031 Held through reset: button_in=0 during reset, reset deasserted before edge r0 -> press_pulse=1 at r0+6; release_pulse stays 0 throughout.
REQ-032 Randomized glitch soak: glitches shorter than 4 cycles for 10000 cycles -> zero pulses, button_out constant, and REQ-021 and REQ-022 hold throughout.
